// File: rtl/frame_pkg.sv
// Shared definitions for the framed serial link.
// Contents:
//   rx_state_t  - receiver state encoding
//   START_BIT / STOP_BIT - line levels of the framing bits
//   CRC_POLY    - CRC-8 generator polynomial (x^8+x^2+x+1)
//   FRAME_BITS  - payload capacity in bits
//   crc8_step   - one serial, MSB-first CRC-8 update
package frame_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SIZE  = 3'd2,
    DATA  = 3'd3,
    CRC   = 3'd4,
    STOP  = 3'd5
  } rx_state_t;

  localparam logic       START_BIT  = 1'b1;
  localparam logic       STOP_BIT   = 1'b0;
  localparam logic [7:0] CRC_POLY   = 8'h07;
  localparam int         FRAME_BITS = 128;

  // Advance the CRC by one received bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic din);
    logic fb;
    fb = din ^ c[7];
    return {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/frame_receiver_crc.sv
// Serial CRC-8 engine shared by the link transmitter and receiver.
// Ports:
//   enable - advance the CRC by one bit this clock
//   clk    - system clock
//   reset  - synchronous, active-high clear to 8'h00
//   in     - serial data bit
//   out    - current CRC value
module frame_receiver_crc
  import frame_pkg::*;
(
  input  logic       enable,
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [7:0] out
);

  // CRC register: clear, advance on enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= 8'h00;
    end else if (enable) begin
      out <= crc8_step(out, in);
    end else begin
      out <= out;
    end
  end

endmodule

// File: rtl/frame_receiver.sv
// Receive side of the framed serial link.
// Frame on RX (MSB first): start(1), size[3:0], size data bytes, crc[7:0], stop(0).
// A size of zero carries no data and no CRC field.
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-high reset
//   RX        - serial line, idles low
//   baudrate  - clocks per bit (0 and 1 act as 2), latched at start detection
//   framesize - byte count of the last frame
//   framebits - last payload, byte 0 in [127:120], unused bytes zero
//   RXI       - high while idle
//   rf        - one-cycle frame-complete pulse
//   crcerr    - with rf: received CRC differs from computed CRC
//   frameerr  - with rf: bad stop bit or zero frame size
module frame_receiver
  import frame_pkg::*;
#(
  parameter int BAUDW    = 8,
  parameter int MAXBYTES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX,
  input  logic [BAUDW-1:0]      baudrate,
  output logic [3:0]            framesize,
  output logic [MAXBYTES*8-1:0] framebits,
  output logic                  RXI,
  output logic                  rf,
  output logic                  crcerr,
  output logic                  frameerr
);

  localparam logic [BAUDW-1:0] CNT_ZERO = {BAUDW{1'b0}};
  localparam logic [BAUDW-1:0] CNT_ONE  = {{(BAUDW-1){1'b0}}, 1'b1};
  localparam logic [BAUDW-1:0] BAUD_MIN = {{(BAUDW-2){1'b0}}, 2'b10};

  rx_state_t             state_r;
  rx_state_t             state_s;
  logic [BAUDW-1:0]      cnt_r;
  logic [BAUDW-1:0]      baud_r;
  logic [BAUDW-1:0]      baud_eff_s;
  logic [BAUDW-1:0]      half_s;
  logic                  wrap_s;
  logic                  sample_s;
  logic                  start_det_s;
  logic                  crc_en_s;
  logic                  crc_rst_s;
  logic [7:0]            crc_s;
  logic [2:0]            bit_r;
  logic [3:0]            byte_r;
  logic [3:0]            size_r;
  logic [3:0]            size_next_s;
  logic [7:0]            rxcrc_r;
  logic                  ferr_pend_r;
  logic [FRAME_BITS-1:0] shadow_r;
  logic [6:0]            idx_s;

  assign baud_eff_s  = (baudrate < BAUD_MIN) ? BAUD_MIN : baudrate;
  assign half_s      = baud_r >> 1'b1;
  assign wrap_s      = (cnt_r == (baud_r - CNT_ONE));
  assign sample_s    = (state_r != IDLE) && (cnt_r == half_s);
  assign size_next_s = {size_r[2:0], RX};
  // Byte k occupies bits [127-8k -: 8]; with 16 bytes (15-k) is simply the complement.
  assign idx_s       = {4'hF - byte_r, bit_r};
  assign crc_rst_s   = reset | start_det_s;

  frame_receiver_crc u_crc (
    .enable (crc_en_s),
    .clk    (clk),
    .reset  (crc_rst_s),
    .in     (RX),
    .out    (crc_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic plus start-detect and CRC-enable strobes.
  always_comb begin
    state_s     = state_r;
    start_det_s = 1'b0;
    crc_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (RX == START_BIT) begin
          state_s     = START;
          start_det_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (sample_s) begin
          if (RX == START_BIT) begin
            state_s = SIZE;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = START;
        end
      end
      SIZE: begin
        if (sample_s) begin
          crc_en_s = 1'b1;
          if (bit_r == 3'd0) begin
            if (size_next_s == 4'h0) begin
              state_s = STOP;
            end else begin
              state_s = DATA;
            end
          end else begin
            state_s = SIZE;
          end
        end else begin
          state_s = SIZE;
        end
      end
      DATA: begin
        if (sample_s) begin
          crc_en_s = 1'b1;
          if ((bit_r == 3'd0) && (byte_r == (size_r - 4'd1))) begin
            state_s = CRC;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      CRC: begin
        if (sample_s && (bit_r == 3'd0)) begin
          state_s = STOP;
        end else begin
          state_s = CRC;
        end
      end
      STOP: begin
        if (sample_s) begin
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Baud counter. The start-detect clock counts as 0, so the counter reads k
  // exactly k clocks after each bit boundary and mid-bit lands on baud/2.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= CNT_ZERO;
      baud_r <= BAUD_MIN;
    end else if (start_det_s) begin
      cnt_r  <= CNT_ONE;
      baud_r <= baud_eff_s;
    end else if (state_r != IDLE) begin
      cnt_r  <= wrap_s ? CNT_ZERO : (cnt_r + CNT_ONE);
      baud_r <= baud_r;
    end else begin
      cnt_r  <= cnt_r;
      baud_r <= baud_r;
    end
  end

  // Field capture: size, payload shadow buffer, received CRC, bit/byte indices.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_r       <= 3'd0;
      byte_r      <= 4'd0;
      size_r      <= 4'd0;
      rxcrc_r     <= 8'h00;
      ferr_pend_r <= 1'b0;
      shadow_r    <= {FRAME_BITS{1'b0}};
    end else if (start_det_s) begin
      bit_r       <= 3'd3;
      byte_r      <= 4'd0;
      size_r      <= 4'd0;
      rxcrc_r     <= 8'h00;
      ferr_pend_r <= 1'b0;
      shadow_r    <= {FRAME_BITS{1'b0}};
    end else if (sample_s) begin
      case (state_r)
        SIZE: begin
          size_r <= size_next_s;
          if (bit_r == 3'd0) begin
            bit_r       <= 3'd7;
            byte_r      <= 4'd0;
            ferr_pend_r <= (size_next_s == 4'h0);
          end else begin
            bit_r <= bit_r - 3'd1;
          end
        end
        DATA: begin
          shadow_r[idx_s] <= RX;
          if (bit_r == 3'd0) begin
            bit_r <= 3'd7;
            if (byte_r != (size_r - 4'd1)) begin
              byte_r <= byte_r + 4'd1;
            end else begin
              byte_r <= byte_r;
            end
          end else begin
            bit_r <= bit_r - 3'd1;
          end
        end
        CRC: begin
          rxcrc_r <= {rxcrc_r[6:0], RX};
          bit_r   <= bit_r - 3'd1;
        end
        default: begin
          bit_r <= bit_r;
        end
      endcase
    end else begin
      bit_r <= bit_r;
    end
  end

  // Output registers: publish the frame and pulse rf on the stop-bit sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      RXI       <= 1'b1;
      rf        <= 1'b0;
      crcerr    <= 1'b0;
      frameerr  <= 1'b0;
      framesize <= 4'd0;
      framebits <= {(MAXBYTES*8){1'b0}};
    end else begin
      RXI <= (state_s == IDLE);
      if ((state_r == STOP) && sample_s) begin
        rf        <= 1'b1;
        crcerr    <= (rxcrc_r != crc_s);
        frameerr  <= ferr_pend_r | (RX != STOP_BIT);
        framesize <= size_r;
        framebits <= shadow_r;
      end else begin
        rf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_receiver.sv
// Self-checking bench for frame_receiver: table of frames, scoreboard of
// expected results checked whenever rf pulses, plus glitch and reset sequences.
module tb_frame_receiver;

  logic         clk;
  logic         reset;
  logic         RX;
  logic [7:0]   baudrate;
  logic [3:0]   framesize;
  logic [127:0] framebits;
  logic         RXI;
  logic         rf;
  logic         crcerr;
  logic         frameerr;

  frame_receiver #(.BAUDW(8), .MAXBYTES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .RX        (RX),
    .baudrate  (baudrate),
    .framesize (framesize),
    .framebits (framebits),
    .RXI       (RXI),
    .rf        (rf),
    .crcerr    (crcerr),
    .frameerr  (frameerr)
  );

  typedef struct {
    logic [7:0]   baud;
    logic [3:0]   size;
    logic [127:0] pay;
    logic         use_model;
    logic [7:0]   crc;
    logic         stop;
    logic         exp_crcerr;
    logic         exp_ferr;
    logic         chk_crc;
  } vec_t;

  typedef struct {
    logic [3:0]   size;
    logic [127:0] bits;
    logic         crcerr;
    logic         ferr;
    logic         chk_crc;
    int           half;
  } exp_t;

  exp_t sb[$];
  logic bitq[$];
  vec_t tbl[9];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   stop_cyc = 0;
  int   n_pushed = 0;
  int   n_rf     = 0;
  logic rf_prev  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference CRC-8 (poly 0x07, init 0) over size bits then data bits, MSB first.
  function automatic logic [7:0] crc_ref(input logic [3:0] size, input logic [127:0] pay);
    logic [7:0] c;
    logic       b;
    c = 8'h00;
    for (int i = 3; i >= 0; i--) begin
      b = size[i] ^ c[7];
      c = {c[6:0], 1'b0} ^ (b ? 8'h07 : 8'h00);
    end
    for (int k = 0; k < size; k++) begin
      for (int j = 7; j >= 0; j--) begin
        b = pay[(15 - k) * 8 + j] ^ c[7];
        c = {c[6:0], 1'b0} ^ (b ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  function automatic vec_t mk(input logic [7:0] baud, input logic [3:0] size,
                              input logic [127:0] pay, input logic use_model,
                              input logic [7:0] crc, input logic stop,
                              input logic ecrc, input logic eferr, input logic chk);
    vec_t v;
    v.baud = baud; v.size = size; v.pay = pay; v.use_model = use_model;
    v.crc = crc; v.stop = stop; v.exp_crcerr = ecrc; v.exp_ferr = eferr; v.chk_crc = chk;
    return v;
  endfunction

  // Drive a frame; nbits < 0 sends it whole and pushes its expected result.
  task automatic send_vec(input vec_t v, input int nbits);
    int         eff;
    logic [7:0] crc;
    exp_t       e;
    eff = (v.baud < 8'd2) ? 2 : int'(v.baud);
    crc = v.use_model ? crc_ref(v.size, v.pay) : v.crc;
    bitq.delete();
    bitq.push_back(1'b1);
    for (int i = 3; i >= 0; i--) bitq.push_back(v.size[i]);
    for (int k = 0; k < v.size; k++)
      for (int j = 7; j >= 0; j--) bitq.push_back(v.pay[(15 - k) * 8 + j]);
    if (v.size != 4'd0)
      for (int i = 7; i >= 0; i--) bitq.push_back(crc[i]);
    bitq.push_back(v.stop);
    if (nbits < 0) begin
      e.size = v.size; e.bits = v.pay; e.crcerr = v.exp_crcerr;
      e.ferr = v.exp_ferr; e.chk_crc = v.chk_crc; e.half = eff / 2;
      sb.push_back(e);
      n_pushed++;
    end
    @(negedge clk);
    baudrate = v.baud;
    for (int i = 0; i < bitq.size(); i++) begin
      if (nbits >= 0 && i >= nbits) break;
      @(negedge clk);
      RX = bitq[i];
      if (i == bitq.size() - 1) stop_cyc = cyc + 1;
      repeat (eff) @(posedge clk);
    end
    if (nbits < 0) begin
      @(negedge clk);
      RX = 1'b0;
      repeat (2 * eff + 4) @(posedge clk);
    end
  endtask

  // Scoreboard: every rf pulse is matched against the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rf) begin
      n_rf++;
      check("rf_single_cycle", rf_prev, 1'b0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rf: got rf=1 expected no frame");
      end else begin
        e = sb.pop_front();
        check("framesize", framesize, e.size);
        check("framebits", framebits, e.bits);
        check("frameerr", frameerr, e.ferr);
        if (e.chk_crc) check("crcerr", crcerr, e.crcerr);
        check("rf_latency", cyc - stop_cyc, e.half);
        check("rxi_with_rf", RXI, 1'b1);
      end
    end
    rf_prev <= rf;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] p15;
    int           w;
    p15 = 128'h0;
    for (int k = 0; k < 15; k++) p15[(15 - k) * 8 +: 8] = 8'(k + 1);
    tbl[0] = mk(8'd4,   4'd1,  {8'hA5, 120'h0},               1'b0, 8'h67, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[1] = mk(8'd4,   4'd1,  {8'hA5, 120'h0},               1'b0, 8'h66, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[2] = mk(8'd10,  4'd15, p15,                           1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[3] = mk(8'd4,   4'd2,  {8'hDE, 8'hAD, 112'h0},        1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[4] = mk(8'd4,   4'd0,  128'h0,                        1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[5] = mk(8'd0,   4'd3,  {8'h11, 8'h22, 8'h33, 104'h0}, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[6] = mk(8'd1,   4'd1,  {8'hFF, 120'h0},               1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[7] = mk(8'd3,   4'd2,  {8'h80, 8'h01, 112'h0},        1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[8] = mk(8'd255, 4'd1,  {8'h3C, 120'h0},               1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    reset = 1'b1; RX = 1'b0; baudrate = 8'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rxi", RXI, 1'b1);
    check("reset_rf", rf, 1'b0);
    check("reset_framesize", framesize, 4'd0);
    check("reset_framebits", framebits, 128'h0);
    check("reset_errs", {crcerr, frameerr}, 2'b00);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) send_vec(tbl[i], -1);

    // Start-bit glitch: RX high for one clock at baudrate 8.
    @(negedge clk);
    baudrate = 8'd8;
    RX = 1'b1;
    @(negedge clk);
    RX = 1'b0;
    check("glitch_rxi_low", RXI, 1'b0);
    w = 0;
    while (RXI !== 1'b1 && w < 8) begin
      @(negedge clk);
      w++;
    end
    check("glitch_rxi_back", w, 4);
    repeat (10) @(posedge clk);

    // Reset in the middle of the data field discards the frame and clears outputs.
    send_vec(tbl[3], 10);
    @(negedge clk);
    reset = 1'b1;
    RX = 1'b0;
    @(negedge clk);
    check("midreset_rxi", RXI, 1'b1);
    check("midreset_framesize", framesize, 4'd0);
    check("midreset_framebits", framebits, 128'h0);
    check("midreset_flags", {rf, crcerr, frameerr}, 3'b000);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    send_vec(tbl[0], -1);

    repeat (20) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    check("rf_count", n_rf, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
